// File: rtl/rgb_seq_pkg.sv
// Shared types and colour codes for the RGB PWM fade sequencer.
package rgb_seq_pkg;
  typedef enum logic [1:0] {IDLE, FADE_IN, HOLD, FADE_OUT} seq_state_t;

  localparam logic [1:0] COL_RED   = 2'd0;
  localparam logic [1:0] COL_GREEN = 2'd1;
  localparam logic [1:0] COL_BLUE  = 2'd2;
endpackage

// File: rtl/rgb_pwm_sequencer_if.sv
// Run request in, PWM drives and status out; master is the sequencer side.
interface rgb_pwm_sequencer_if;
  logic       en;
  logic       pwm_red;
  logic       pwm_green;
  logic       pwm_blue;
  logic [1:0] colour;
  logic       busy;
  logic       seq_done;

  modport master (input en, output pwm_red, pwm_green, pwm_blue, colour, busy, seq_done);
  modport slave  (output en, input pwm_red, pwm_green, pwm_blue, colour, busy, seq_done);
endinterface

// File: rtl/rgb_pwm_sequencer_timebase.sv
// Prescaler plus free-running PWM counter; both parked at 0 while not running.
module pwm_timebase #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 48
) (
  input  logic                int_osc,
  input  logic                rst_n,
  input  logic                run,
  output logic [PWM_BITS-1:0] pwm_cnt,
  output logic                tick,
  output logic                period_end
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0] pre_cnt;

  assign tick       = run && (pre_cnt == PW'(PRESCALE - 1));
  assign period_end = tick && (pwm_cnt == {PWM_BITS{1'b1}});

  always_ff @(posedge int_osc or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else if (!run) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/rgb_pwm_sequencer.sv
// Fades red, green, blue in turn (in / hold / out) and drives the three RGB PWM pins.
module rgb_pwm_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int PWM_BITS     = 8,
  parameter int PRESCALE     = 48,
  parameter int STEP_PERIODS = 4,
  parameter int HOLD_PERIODS = 64
) (
  input  logic                 int_osc,
  input  logic                 rst_n,
  rgb_pwm_sequencer_if.master  bus
);
  localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam int HW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
  localparam logic [PWM_BITS-1:0] DUTY_MAX = {PWM_BITS{1'b1}};

  seq_state_t          state, state_nxt;
  logic [PWM_BITS-1:0] duty, duty_nxt, pwm_cnt;
  logic [1:0]          colour, colour_nxt;
  logic [SW-1:0]       step_cnt, step_nxt;
  logic [HW-1:0]       hold_cnt, hold_nxt;
  logic                done_nxt, seq_done_q;
  logic                pwm_r, pwm_g, pwm_b;
  logic                period_end, tick_unused;
  logic                step_due;

  pwm_timebase #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) u_tb (
    .int_osc    (int_osc),
    .rst_n      (rst_n),
    .run        (state != IDLE),
    .pwm_cnt    (pwm_cnt),
    .tick       (tick_unused),
    .period_end (period_end)
  );

  assign step_due = period_end && (step_cnt == SW'(STEP_PERIODS - 1));

  always_comb begin
    state_nxt  = state;
    duty_nxt   = duty;
    colour_nxt = colour;
    step_nxt   = step_cnt;
    hold_nxt   = hold_cnt;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (bus.en) begin
        state_nxt  = FADE_IN;
        duty_nxt   = '0;
        colour_nxt = COL_RED;
      end
      FADE_IN: if (period_end) begin
        step_nxt = step_cnt + 1'b1;
        if (step_due) begin
          step_nxt = '0;
          if (duty != DUTY_MAX) duty_nxt = duty + 1'b1;
          if (duty >= DUTY_MAX - 1'b1) state_nxt = HOLD;
        end
      end
      HOLD: if (period_end) begin
        hold_nxt = hold_cnt + 1'b1;
        // Leaving HOLD is the first fade-out step, so max duty lasts exactly HOLD_PERIODS.
        if (hold_cnt == HW'(HOLD_PERIODS - 1)) begin
          state_nxt = FADE_OUT;
          if (duty != '0) duty_nxt = duty - 1'b1;
        end
      end
      FADE_OUT: if (period_end) begin
        step_nxt = step_cnt + 1'b1;
        if (step_due) begin
          step_nxt = '0;
          if (duty != '0) duty_nxt = duty - 1'b1;
          if (duty <= 1) begin
            state_nxt  = FADE_IN;
            colour_nxt = (colour == COL_BLUE) ? COL_RED : colour + 2'd1;
            done_nxt   = (colour == COL_BLUE);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A stop request takes effect only at a period boundary and beats a wrap.
    if (state != IDLE && period_end && !bus.en) begin
      state_nxt  = IDLE;
      duty_nxt   = '0;
      colour_nxt = COL_RED;
      done_nxt   = 1'b0;
    end

    if (state_nxt != state) begin
      step_nxt = '0;
      hold_nxt = '0;
    end
  end

  always_ff @(posedge int_osc or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      duty       <= '0;
      colour     <= COL_RED;
      step_cnt   <= '0;
      hold_cnt   <= '0;
      seq_done_q <= 1'b0;
      pwm_r      <= 1'b0;
      pwm_g      <= 1'b0;
      pwm_b      <= 1'b0;
    end else begin
      state      <= state_nxt;
      duty       <= duty_nxt;
      colour     <= colour_nxt;
      step_cnt   <= step_nxt;
      hold_cnt   <= hold_nxt;
      seq_done_q <= done_nxt;
      pwm_r      <= (colour == COL_RED)   && (pwm_cnt < duty);
      pwm_g      <= (colour == COL_GREEN) && (pwm_cnt < duty);
      pwm_b      <= (colour == COL_BLUE)  && (pwm_cnt < duty);
    end
  end

  assign bus.pwm_red   = pwm_r;
  assign bus.pwm_green = pwm_g;
  assign bus.pwm_blue  = pwm_b;
  assign bus.colour    = colour;
  assign bus.busy      = (state != IDLE);
  assign bus.seq_done  = seq_done_q;
endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// Directed bench: PWM_BITS=3, PRESCALE=2, STEP=1, HOLD=2 -> 16-cycle periods, 15 periods per colour.
module tb_rgb_pwm_sequencer;
  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_done = 0;

  rgb_pwm_sequencer_if bus ();

  rgb_pwm_sequencer #(
    .PWM_BITS(3), .PRESCALE(2), .STEP_PERIODS(1), .HOLD_PERIODS(2)
  ) dut (
    .int_osc (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Period w after FADE_IN entry: 0..6 fade in, 7,7 hold, 6..1 fade out, then next colour.
  function automatic int exp_duty(input int w);
    int i;
    i = w % 15;
    if (i < 7) return i;
    if (i < 9) return 7;
    return 15 - i;
  endfunction

  function automatic int exp_col(input int w);
    return (w / 15) % 3;
  endfunction

  // Samples one 16-cycle PWM period (#1 after each edge) and checks high-times per channel.
  task automatic run_window(input int w, input int drop_at, input int raise_at);
    int hr, hg, hb, d, c;
    logic [1:0] col0;
    hr = 0; hg = 0; hb = 0; col0 = 2'd3;
    for (int s = 0; s < 16; s++) begin
      if (s == drop_at)  bus.en = 1'b0;
      if (s == raise_at) bus.en = 1'b1;
      @(posedge clk);
      #1;
      hr += int'(bus.pwm_red);
      hg += int'(bus.pwm_green);
      hb += int'(bus.pwm_blue);
      if (s == 0) col0 = bus.colour;
      if (bus.seq_done) begin
        n_done++;
        chk($sformatf("w%0d done_colour", w), 32'(bus.colour), 32'd0);
      end
    end
    d = exp_duty(w);
    c = exp_col(w);
    chk($sformatf("w%0d colour", w), 32'(col0), 32'(c));
    chk($sformatf("w%0d red_hi", w), 32'(hr), (c == 0) ? 32'(2 * d) : 32'd0);
    chk($sformatf("w%0d green_hi", w), 32'(hg), (c == 1) ? 32'(2 * d) : 32'd0);
    chk($sformatf("w%0d blue_hi", w), 32'(hb), (c == 2) ? 32'(2 * d) : 32'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " red"},   32'(bus.pwm_red),   32'd0);
    chk({tag, " green"}, 32'(bus.pwm_green), 32'd0);
    chk({tag, " blue"},  32'(bus.pwm_blue),  32'd0);
    chk({tag, " colour"}, 32'(bus.colour),   32'd0);
    chk({tag, " busy"},  32'(bus.busy),      32'd0);
    chk({tag, " done"},  32'(bus.seq_done),  32'd0);
  endtask

  initial begin
    int act;
    rst_n  = 1'b0;
    bus.en = 1'b1;

    // Reset held with en high
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset");

    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("start busy", 32'(bus.busy), 32'd1);

    // Red/green/blue full cycle, wrap, red restart; window 47 cancels a stop request
    for (int w = 0; w < 52; w++) begin
      if (w == 47) run_window(w, 3, 10);
      else         run_window(w, -1, -1);
      if (w == 46) chk("seq_done count", 32'(n_done), 32'd1);
    end

    // Stop during red HOLD (window 52): period completes, then IDLE
    run_window(52, 8, -1);
    chk_quiet("stopped");
    act = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      act += int'(bus.pwm_red | bus.pwm_green | bus.pwm_blue | bus.busy | bus.seq_done);
    end
    chk("idle activity", 32'(act), 32'd0);

    // Restart from red at duty 0
    bus.en = 1'b1;
    @(posedge clk);
    #1;
    chk("restart busy", 32'(bus.busy), 32'd1);
    for (int w = 0; w < 26; w++) run_window(w, -1, -1);

    // Green fade-out at duty 4: async reset clears outputs before the next edge
    repeat (3) @(posedge clk);
    #1;
    chk("pre-reset green", 32'(bus.pwm_green), 32'd1);
    chk("pre-reset colour", 32'(bus.colour), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("async reset");
    chk("seq_done total", 32'(n_done), 32'd1);
    #10;
    rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
